// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and hands
// {if_valid, if_pc, if_inst} to decode. Define FETCH_ICOUNT_EN to add the fetch_count output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
`ifdef FETCH_ICOUNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        fetch_misalign
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc_q;
  logic        misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Redirect beats stall; a stall re-reads the same word so imem_dout stays stable.
  always_comb begin
    imem_addr = fetch_pc_q + 32'd4;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr = {redirect_pc[31:2], 2'b00};
    end else if (state_q == BOOT) begin
      imem_addr = RESET_PC;
    end else if (stall) begin
      imem_addr = fetch_pc_q;
    end
  end

  // The wrong-path word is squashed in the redirect cycle itself.
  always_comb begin
    if_valid       = (state_q == RUN) && !redirect_valid;
    if_pc          = fetch_pc_q;
    if_inst        = if_valid ? imem_dout : NOP_INST;
    fetch_misalign = misalign_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= imem_addr;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_ICOUNT_EN
  // Counts instructions actually handed to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (if_valid && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push expected outputs,
// a monitor on the falling edge pops and compares. Build with FETCH_ICOUNT_EN to check the counter.
module tb_fetch_stage;

  localparam logic [31:0] B   = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
    logic [31:0] ecnt;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_misalign;
`ifdef FETCH_ICOUNT_EN
  logic [31:0] fetch_count;
`endif

  vec_t vecs[$];
  vec_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
`ifdef FETCH_ICOUNT_EN
    .fetch_count    (fetch_count),
`endif
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory returns an address-derived word one cycle later.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a;
  endfunction

  always @(posedge clk) imem_dout <= inst_of(imem_addr);

  task automatic add_vec(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                         input logic chk, input logic ev, input logic [31:0] epc,
                         input logic [31:0] eaddr, input logic emis, input logic [31:0] ecnt);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.chk = chk; v.ev = ev;
    v.epc = epc; v.eaddr = eaddr; v.emis = emis; v.ecnt = ecnt; v.cyc = vecs.size();
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    if (v.chk) exp_q.push_back(v);
  endtask

  task automatic checkOutput(input vec_t e);
    cmp("if_valid", e.cyc, {31'd0, if_valid}, {31'd0, e.ev});
    cmp("if_pc", e.cyc, if_pc, e.epc);
    cmp("if_inst", e.cyc, if_inst, e.ev ? inst_of(e.epc) : NOP);
    cmp("imem_addr", e.cyc, imem_addr, e.eaddr);
    cmp("fetch_misalign", e.cyc, {31'd0, fetch_misalign}, {31'd0, e.emis});
`ifdef FETCH_ICOUNT_EN
    cmp("fetch_count", e.cyc, fetch_count, e.ecnt);
`endif
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expected entry.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    //       rst stall rv rpc           chk ev  epc            eaddr          mis cnt
    add_vec(1, 0, 0, 32'd0,          0, 0, B,             B,             0, 0);  // c0
    add_vec(1, 0, 0, 32'd0,          1, 0, B,             B,             0, 0);  // c1
    add_vec(0, 0, 0, 32'd0,          1, 0, B,             B,             0, 0);  // c2 BOOT
    add_vec(0, 0, 0, 32'd0,          1, 1, B,             B + 32'h04,    0, 0);  // c3 first valid
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h04,    B + 32'h08,    0, 1);
    add_vec(0, 1, 0, 32'd0,          1, 1, B + 32'h08,    B + 32'h08,    0, 2);  // c5 stall x3
    add_vec(0, 1, 0, 32'd0,          1, 1, B + 32'h08,    B + 32'h08,    0, 2);
    add_vec(0, 1, 0, 32'd0,          1, 1, B + 32'h08,    B + 32'h08,    0, 2);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h08,    B + 32'h0C,    0, 2);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h0C,    B + 32'h10,    0, 3);
    add_vec(0, 0, 1, B + 32'h100,    1, 0, B + 32'h10,    B + 32'h100,   0, 4);  // c10 redirect
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h100,   B + 32'h104,   0, 4);
    add_vec(0, 1, 1, B + 32'h200,    1, 0, B + 32'h104,   B + 32'h200,   0, 5);  // c12 redirect+stall
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h200,   B + 32'h204,   0, 5);
    add_vec(0, 0, 1, B + 32'h102,    1, 0, B + 32'h204,   B + 32'h100,   0, 6);  // c14 misaligned
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h100,   B + 32'h104,   1, 6);
    add_vec(0, 0, 1, B + 32'h38,     1, 0, B + 32'h104,   B + 32'h38,    1, 7);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h38,    B + 32'h3C,    1, 7);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h3C,    B + 32'h40,    1, 8);
    add_vec(1, 0, 0, 32'd0,          1, 1, B + 32'h40,    B,             1, 9);  // c19 mid-stream reset
    add_vec(0, 0, 0, 32'd0,          1, 0, B,             B,             0, 0);
    add_vec(0, 0, 0, 32'd0,          1, 1, B,             B + 32'h04,    0, 0);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h04,    B + 32'h08,    0, 1);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h08,    B + 32'h0C,    0, 2);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h0C,    B + 32'h10,    0, 3);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h10,    B + 32'h14,    0, 4);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h14,    B + 32'h18,    0, 5);  // c26 five counted
    add_vec(0, 0, 1, 32'hFFFF_FFF8,  1, 0, B + 32'h18,    32'hFFFF_FFF8, 0, 6);  // c27 wrap test
    add_vec(0, 0, 0, 32'd0,          1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 6);
    add_vec(0, 0, 0, 32'd0,          1, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 7);
    add_vec(0, 0, 0, 32'd0,          1, 1, 32'h0000_0000, 32'h0000_0004, 0, 8);
    add_vec(1, 0, 0, 32'd0,          1, 1, 32'h0000_0004, B,             0, 9);  // c31 reset
    add_vec(0, 1, 1, B + 32'h300,    1, 0, B,             B + 32'h300,   0, 0);  // c32 redirect in BOOT
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h300,   B + 32'h304,   0, 0);
    add_vec(0, 0, 0, 32'd0,          1, 1, B + 32'h304,   B + 32'h308,   0, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    redirect_valid = 1'b0;

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the riscv_core pipeline, directly upstream of the opcode control decoder.
- Owns the PC and drives the synchronous-read instruction memory address (1-cycle read latency).
- Presents `{if_valid, if_pc, if_inst}` to decode.
- Handles boot from RESET_PC, downstream stall (hold), and redirects from jump/branch resolution.
- Injects a canonical NOP whenever no valid instruction exists, so decode never asserts reg_write or mem_write on a bubble.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset (BIOS base).
- NOP_INST, 32'h0000_0013, instruction substituted on bubbles (addi x0,x0,0; rd=0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  downstream not accepting; hold current instruction.
- redirect_valid  input  1  taken branch/jal/jalr resolved; refetch from redirect_pc.
- redirect_pc  input  32  redirect target.
- imem_addr  output  32  byte address to instruction memory (combinational).
- imem_dout  input  32  instruction for the address presented in the previous cycle.
- if_valid  output  1  if_inst/if_pc are a real, correct-path instruction.
- if_pc  output  32  PC of if_inst.
- if_inst  output  32  instruction to decode; NOP_INST when if_valid=0.
- fetch_misalign  output  1  sticky flag: a redirect target had bits[1:0]!=0.

Behaviour:
- State: `state_q` ∈ {BOOT, RUN}; `fetch_pc_q` (32b) = address presented last cycle; `misalign_q`.
- rst=1 (any cycle, including mid-operation):
  - Next state BOOT; `fetch_pc_q` ← RESET_PC; `misalign_q` ← 0.
  - imem_addr = RESET_PC while rst is high.
  - Outputs in the first cycle after reset: if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST, fetch_misalign=0.
- BOOT (one cycle):
  - imem_addr = RESET_PC; if_valid=0.
  - Next state RUN; `fetch_pc_q` ← RESET_PC. Stall is ignored in BOOT.
  - redirect_valid in BOOT is honoured: imem_addr = aligned redirect_pc.
- RUN, imem_addr priority:
  1. redirect_valid → {redirect_pc[31:2], 2'b00}
  2. stall → fetch_pc_q (re-read same word so imem_dout stays stable)
  3. otherwise → fetch_pc_q + 4, 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- Every non-reset cycle: `fetch_pc_q` ← imem_addr.
- Outputs in RUN:
  - if_pc = fetch_pc_q.
  - if_inst = if_valid ? imem_dout : NOP_INST.
  - if_valid = (state_q==RUN) && !redirect_valid.
  - The wrong-path instruction is squashed combinationally in the redirect cycle; the target instruction appears valid the following cycle, so a redirect costs exactly one bubble.
- Redirect and stall in the same cycle: redirect wins; stall has no effect on that cycle's address.
- Stall held N cycles: if_pc/if_inst/if_valid constant for N cycles; advance on the first cycle with stall=0.
- Misalignment: redirect_valid with redirect_pc[1:0]!=0 sets misalign_q, which stays set until rst. Fetch continues at the aligned address.
- Latency: redirect to target instruction valid = 1 cycle; reset deassert to first valid instruction = 2 cycles.

Optional Feature:
- Macro: FETCH_ICOUNT_EN.
- When defined:
  - Extra output port `fetch_count` (32b): number of cycles with if_valid=1 && stall=0, i.e. instructions handed to decode.
  - Reset to 0; wraps at 2^32; does not count squashed or stalled cycles.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, no stall, imem returns addr-derived words → imem_addr 4000_0000, 4000_0004, 4000_0008…; if_valid first high 2 cycles after rst falls, with if_pc=4000_0000.
- stall held 3 cycles at if_pc=4000_0008 → imem_addr=4000_0008 for those 3 cycles; if_inst/if_pc unchanged; next PC 4000_000C after release.
- redirect_valid with redirect_pc=4000_0100 while if_pc=4000_0010 → that cycle if_valid=0, if_inst=0000_0013; next cycle if_pc=4000_0100, valid.
- redirect and stall together, redirect_pc=4000_0200 → imem_addr=4000_0200; next cycle if_pc=4000_0200.
- redirect_pc=4000_0102 → fetch_misalign=1 from the next cycle and persists; if_pc=4000_0100; only rst clears it.
- rst asserted mid-stream at if_pc=4000_0040 → next cycle if_valid=0, if_pc=4000_0000, fetch_misalign=0; fetch_count=0 with FETCH_ICOUNT_EN; after 5 unstalled valid cycles fetch_count=5.
